// File: rtl/x25519_arb_pkg.sv
// Shared types and default constants for the X25519 accelerator arbiter.
// Holds the arbiter state encoding and the counter width helper.
package x25519_arb_pkg;

    typedef enum logic [2:0] {
        DRAIN,
        IDLE,
        ISSUE,
        BUSY,
        DONE
    } arb_state_e;

    localparam int unsigned DEF_DATA_WIDTH     = 256;
    localparam int unsigned DEF_DRAIN_CYCLES   = 16384;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32768;

    // One counter serves both the drain window and the busy watchdog.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/x25519_arbiter_rr_arbiter.sv
// Combinational cyclic-priority picker: first set request at or after ptr.
// Produces a one-hot grant plus its binary index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       any_req
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic             found;
    int               sum;
    logic [IDX_W-1:0] k;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = 0;
        k       = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sum = int'(ptr) + i;
            if (sum >= int'(NUM_REQ)) begin
                sum = sum - int'(NUM_REQ);
            end
            k = IDX_W'(sum);
            if (!found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = k;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/x25519_arbiter.sv
// Round-robin owner of the single X25519 scalar-mult accelerator.
// Optional BUSY watchdog with resp_error: define X25519_ARB_TIMEOUT_EN.
module x25519_arbiter
    import x25519_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk_250mhz,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_work_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_e,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [NUM_REQ-1:0]            resp_error,
    output logic [DATA_WIDTH-1:0]         resp_work_out,
    output logic                          crypt_en,
    output logic [DATA_WIDTH-1:0]         crypt_work_in,
    output logic [DATA_WIDTH-1:0]         crypt_e,
    input  logic                          crypt_out_valid,
    input  logic [DATA_WIDTH-1:0]         crypt_work_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(DRAIN_CYCLES, TIMEOUT_CYCLES);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_work_out_q, resp_work_out_d;
    logic                  crypt_en_q, crypt_en_d;
    logic [DATA_WIDTH-1:0] crypt_work_in_q, crypt_work_in_d;
    logic [DATA_WIDTH-1:0] crypt_e_q, crypt_e_d;
`ifdef X25519_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0]    resp_error_q, resp_error_d;
`endif

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic [IDX_W-1:0]   next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any_req (any_req)
    );

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        ptr_d           = ptr_q;
        owner_d         = owner_q;
        grant_d         = grant_q;
        resp_valid_d    = '0;
        resp_work_out_d = resp_work_out_q;
        crypt_en_d      = 1'b0;
        crypt_work_in_d = crypt_work_in_q;
        crypt_e_d       = crypt_e_q;
`ifdef X25519_ARB_TIMEOUT_EN
        resp_error_d    = '0;
`endif
        unique case (state_q)
            // The accelerator has no reset, so a result may still be in flight.
            DRAIN: begin
                if (crypt_out_valid || cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (any_req) begin
                    grant_d         = pick_gnt;
                    owner_d         = pick_idx;
                    crypt_work_in_d = req_work_in[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    crypt_e_d       = req_e[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                    state_d         = ISSUE;
                end
            end
            ISSUE: begin
                crypt_en_d = 1'b1;
                cnt_d      = '0;
                state_d    = BUSY;
            end
            BUSY: begin
                if (crypt_out_valid) begin
                    resp_work_out_d = crypt_work_out;
                    resp_valid_d    = grant_q;
                    ptr_d           = next_ptr;
                    state_d         = DONE;
                end
`ifdef X25519_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_error_d = grant_q;
                    ptr_d        = next_ptr;
                    grant_d      = '0;
                    cnt_d        = '0;
                    state_d      = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                grant_d = '0;
                state_d = DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk_250mhz) begin
        if (!rst_n) begin
            state_q         <= DRAIN;
            cnt_q           <= '0;
            ptr_q           <= '0;
            owner_q         <= '0;
            grant_q         <= '0;
            resp_valid_q    <= '0;
            resp_work_out_q <= '0;
            crypt_en_q      <= 1'b0;
            crypt_work_in_q <= '0;
            crypt_e_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            ptr_q           <= ptr_d;
            owner_q         <= owner_d;
            grant_q         <= grant_d;
            resp_valid_q    <= resp_valid_d;
            resp_work_out_q <= resp_work_out_d;
            crypt_en_q      <= crypt_en_d;
            crypt_work_in_q <= crypt_work_in_d;
            crypt_e_q       <= crypt_e_d;
        end
    end

`ifdef X25519_ARB_TIMEOUT_EN
    always_ff @(posedge clk_250mhz) begin
        if (!rst_n) begin
            resp_error_q <= '0;
        end else begin
            resp_error_q <= resp_error_d;
        end
    end

    assign resp_error = resp_error_q;
`else
    assign resp_error = '0;
`endif

    assign grant         = grant_q;
    assign resp_valid    = resp_valid_q;
    assign resp_work_out = resp_work_out_q;
    assign crypt_en      = crypt_en_q;
    assign crypt_work_in = crypt_work_in_q;
    assign crypt_e       = crypt_e_q;

endmodule

// File: tb/tb_x25519_arbiter.sv
// Directed self-checking bench for x25519_arbiter (NUM_REQ=2, short drain).
// The timeout scenario runs only when X25519_ARB_TIMEOUT_EN is defined.
module tb_x25519_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 256;
    localparam int DRN = 200;
    localparam int TMO = 64;

    logic             clk_250mhz = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_work_in;
    logic [NR*DW-1:0] req_e;
    logic [NR-1:0]    grant;
    logic [NR-1:0]    resp_valid;
    logic [NR-1:0]    resp_error;
    logic [DW-1:0]    resp_work_out;
    logic             crypt_en;
    logic [DW-1:0]    crypt_work_in;
    logic [DW-1:0]    crypt_e;
    logic             crypt_out_valid;
    logic [DW-1:0]    crypt_work_out;

    int checks = 0;
    int errors = 0;

    always #2 clk_250mhz = ~clk_250mhz;

    x25519_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .DRAIN_CYCLES   (DRN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_250mhz      (clk_250mhz),
        .rst_n           (rst_n),
        .req             (req),
        .req_work_in     (req_work_in),
        .req_e           (req_e),
        .grant           (grant),
        .resp_valid      (resp_valid),
        .resp_error      (resp_error),
        .resp_work_out   (resp_work_out),
        .crypt_en        (crypt_en),
        .crypt_work_in   (crypt_work_in),
        .crypt_e         (crypt_e),
        .crypt_out_valid (crypt_out_valid),
        .crypt_work_out  (crypt_work_out)
    );

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_250mhz);
        #1;
    endtask

    function automatic logic [NR-1:0] onehot(input int o);
        logic [NR-1:0] v;
        v = '0;
        v[o] = 1'b1;
        return v;
    endfunction

    task automatic set_req(input int o, input logic [DW-1:0] wi,
                           input logic [DW-1:0] e);
        req_work_in[o*DW +: DW] = wi;
        req_e[o*DW +: DW]       = e;
        req[o]                  = 1'b1;
    endtask

    task automatic wait_issue(input int o, input logic [DW-1:0] wi,
                              input logic [DW-1:0] e, input string tag,
                              output int lat);
        lat = 0;
        while (crypt_en !== 1'b1 && lat < 60) begin
            tick;
            lat++;
        end
        check({tag, " crypt_en"}, crypt_en, 1);
        check({tag, " grant"}, grant, onehot(o));
        check({tag, " work_in"}, crypt_work_in, wi);
        check({tag, " e"}, crypt_e, e);
    endtask

    task automatic finish_op(input int o, input logic [DW-1:0] res,
                             input string tag);
        int en_seen;
        en_seen = 0;
        repeat (4) begin
            tick;
            if (crypt_en === 1'b1) en_seen++;
        end
        check({tag, " en quiet in busy"}, en_seen, 0);
        crypt_work_out  = res;
        crypt_out_valid = 1'b1;
        tick;
        crypt_out_valid = 1'b0;
        crypt_work_out  = '0;
        check({tag, " resp_valid"}, resp_valid, onehot(o));
        check({tag, " resp_work_out"}, resp_work_out, res);
        req[o] = 1'b0;
        tick;
        check({tag, " resp_valid drop"}, resp_valid, 0);
        check({tag, " grant clear"}, grant, 0);
        check({tag, " result hold"}, resp_work_out, res);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " grant"}, grant, 0);
        check({tag, " resp_valid"}, resp_valid, 0);
        check({tag, " resp_error"}, resp_error, 0);
        check({tag, " crypt_en"}, crypt_en, 0);
        check({tag, " resp_work_out"}, resp_work_out, 0);
        check({tag, " crypt_work_in"}, crypt_work_in, 0);
        check({tag, " crypt_e"}, crypt_e, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int o;
        rst_n           = 1'b0;
        req             = '0;
        req_work_in     = '0;
        req_e           = '0;
        crypt_out_valid = 1'b0;
        crypt_work_out  = '0;
        tick;
        tick;
        check_all_zero("reset");

        // Test 1a: stale out_valid at drain cycle 100 ends DRAIN early
        rst_n = 1'b1;
        set_req(0, 'h77, 'h33);
        repeat (100) tick;
        crypt_work_out  = 'hDEAD;
        crypt_out_valid = 1'b1;
        tick;
        crypt_out_valid = 1'b0;
        crypt_work_out  = '0;
        check("t1a grant in idle", grant, 0);
        check("t1a no resp_valid", resp_valid, 0);
        check("t1a stale discarded", resp_work_out, 0);
        tick;
        check("t1a granted", grant, 2'b01);
        wait_issue(0, 'h77, 'h33, "t1a", lat);
        finish_op(0, 'h1111, "t1a");

        // Test 1b: without out_valid, DRAIN lasts exactly DRN cycles
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        set_req(0, 'h12, 'h34);
        repeat (DRN) tick;
        check("t1b no grant at drain end", grant, 0);
        tick;
        check("t1b grant after drain", grant, 2'b01);
        wait_issue(0, 'h12, 'h34, "t1b", lat);
        finish_op(0, 'h2222, "t1b");

        // Test 2: single request, latency 2
        set_req(0, 'd9, 'd5);
        wait_issue(0, 'd9, 'd5, "t2", lat);
        check("t2 latency", lat, 2);
        finish_op(0, 'hABCD, "t2");

        // Test 3: both requesting, fresh pointer -> 0,1,0,1
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        repeat (DRN) tick;
        set_req(0, 'h1000, 'h2000);
        set_req(1, 'h1001, 'h2001);
        for (int op = 0; op < 4; op++) begin
            o = op % 2;
            wait_issue(o, DW'('h1000 + op), DW'('h2000 + op), "t3", lat);
            check("t3 latency", lat, 2);
            finish_op(o, DW'('h3000 + op), "t3");
            if (op + 2 < 4) begin
                set_req(o, DW'('h1000 + op + 2), DW'('h2000 + op + 2));
            end
        end

        // Test 4: request arriving while another owner is busy
        set_req(0, 'h44, 'h55);
        wait_issue(0, 'h44, 'h55, "t4 r0", lat);
        set_req(1, 'h66, 'h77);
        finish_op(0, 'h88, "t4 r0");
        wait_issue(1, 'h66, 'h77, "t4 r1", lat);
        check("t4 r1 latency", lat, 2);
        finish_op(1, 'h99, "t4 r1");

`ifdef X25519_ARB_TIMEOUT_EN
        // Test 5: watchdog fires after TMO busy cycles
        set_req(0, 'h500, 'h501);
        wait_issue(0, 'h500, 'h501, "t5", lat);
        repeat (TMO - 1) tick;
        check("t5 no early error", resp_error, 0);
        tick;
        check("t5 resp_error", resp_error, 2'b01);
        check("t5 grant cleared", grant, 0);
        check("t5 no resp_valid", resp_valid, 0);
        req[0] = 1'b0;
        tick;
        check("t5 error pulse", resp_error, 0);
        repeat (8) tick;
        crypt_work_out  = 'hBAD;
        crypt_out_valid = 1'b1;
        tick;
        crypt_out_valid = 1'b0;
        crypt_work_out  = '0;
        check("t5 late valid ignored", resp_valid, 0);
        check("t5 result unchanged", resp_work_out, 'h99);
        set_req(1, 'h510, 'h511);
        wait_issue(1, 'h510, 'h511, "t5 r1", lat);
        check("t5 r1 latency", lat, 2);
        finish_op(1, 'h5151, "t5 r1");
`else
        // No watchdog: BUSY waits indefinitely without an error
        set_req(0, 'h500, 'h501);
        wait_issue(0, 'h500, 'h501, "t5", lat);
        repeat (TMO + 20) tick;
        check("t5 still owned", grant, 2'b01);
        check("t5 no error", resp_error, 0);
        finish_op(0, 'h5151, "t5");
`endif

        // Test 6: reset mid-BUSY, then stale out_valid absorbed in DRAIN
        set_req(0, 'h600, 'h601);
        wait_issue(0, 'h600, 'h601, "t6", lat);
        repeat (3) tick;
        rst_n = 1'b0;
        tick;
        check_all_zero("t6 reset");
        rst_n = 1'b1;
        repeat (5) tick;
        crypt_work_out  = 'hBEEF;
        crypt_out_valid = 1'b1;
        tick;
        crypt_out_valid = 1'b0;
        crypt_work_out  = '0;
        check("t6 stale no resp_valid", resp_valid, 0);
        check("t6 stale result dropped", resp_work_out, 0);
        check("t6 no grant yet", grant, 0);
        tick;
        check("t6 regrant", grant, 2'b01);
        check("t6 still no resp_valid", resp_valid, 0);
        wait_issue(0, 'h600, 'h601, "t6b", lat);
        finish_op(0, 'h6666, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
